// File: rtl/pong_match_if.sv
// Control/status bundle between the pong match sequencer and the frame/datapath side.
interface pong_match_if #(
  parameter int SCORE_W = 4
);
  // No valid/ready here: every input and output is a one-cycle pulse or a
  // level, sampled on each rising clk edge. Pulses are meaningful only in
  // the cycle they are high; levels hold until the driver changes them.
  logic                   frame_tick;
  logic                   start_btn;
  logic                   pause;
  logic                   miss_left;
  logic                   miss_right;
  logic                   phys_en;
  logic                   ball_reset;
  logic                   serve_dir;
  logic [2*SCORE_W-1:0]   score;
  logic [2:0]             state;
  logic                   game_over;
  logic                   winner;

  modport master (
    output frame_tick, start_btn, pause, miss_left, miss_right,
    input  phys_en, ball_reset, serve_dir, score, state, game_over, winner
  );

  modport slave (
    input  frame_tick, start_btn, pause, miss_left, miss_right,
    output phys_en, ball_reset, serve_dir, score, state, game_over, winner
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Match sequencer for pong: gates physics steps, serves the ball and keeps score.
module pong_match_ctrl #(
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 9,
  parameter int SCORE_W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pong_match_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_SCORED = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t             st;
  logic [7:0]         cnt;
  logic [SCORE_W-1:0] player_score;
  logic [SCORE_W-1:0] opp_score;
  logic               pend_player;
  logic               start_q;
  logic               phys_en_r;
  logic               ball_reset_r;
  logic               serve_dir_r;
  logic               game_over_r;
  logic               winner_r;
  logic               start_rise;
  logic [SCORE_W-1:0] player_next;
  logic [SCORE_W-1:0] opp_next;

  // A held button must not restart a finished match; only a fresh press counts.
  assign start_rise  = bus.start_btn & ~start_q;
  assign player_next = player_score + 1'b1;
  assign opp_next    = opp_score + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st           <= S_IDLE;
      cnt          <= 8'd0;
      player_score <= '0;
      opp_score    <= '0;
      pend_player  <= 1'b0;
      start_q      <= 1'b0;
      phys_en_r    <= 1'b0;
      ball_reset_r <= 1'b0;
      serve_dir_r  <= 1'b1;
      game_over_r  <= 1'b0;
      winner_r     <= 1'b0;
    end else begin
      start_q      <= bus.start_btn;
      phys_en_r    <= 1'b0;
      ball_reset_r <= 1'b0;
      case (st)
        S_IDLE, S_OVER: begin
          if (start_rise) begin
            st           <= S_SERVE;
            player_score <= '0;
            opp_score    <= '0;
            serve_dir_r  <= 1'b1;
            winner_r     <= 1'b0;
            game_over_r  <= 1'b0;
            ball_reset_r <= 1'b1;
            cnt          <= 8'(SERVE_DELAY);
          end
        end
        S_SERVE: begin
          if (bus.frame_tick && !bus.pause) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) st <= S_PLAY;
          end
        end
        S_PLAY: begin
          // A miss always takes priority over a physics step in the same cycle.
          if (bus.miss_left && bus.miss_right) begin
            st           <= S_SERVE;
            ball_reset_r <= 1'b1;
            cnt          <= 8'(SERVE_DELAY);
          end else if (bus.miss_left) begin
            st          <= S_SCORED;
            pend_player <= 1'b1;
            serve_dir_r <= 1'b0;
          end else if (bus.miss_right) begin
            st          <= S_SCORED;
            pend_player <= 1'b0;
            serve_dir_r <= 1'b1;
          end else begin
            phys_en_r <= bus.frame_tick & ~bus.pause;
          end
        end
        S_SCORED: begin
          if (pend_player) player_score <= player_next;
          else             opp_score    <= opp_next;
          if ((pend_player ? player_next : opp_next) == SCORE_W'(WIN_SCORE)) begin
            st          <= S_OVER;
            winner_r    <= pend_player;
            game_over_r <= 1'b1;
          end else begin
            st           <= S_SERVE;
            ball_reset_r <= 1'b1;
            cnt          <= 8'(SERVE_DELAY);
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.phys_en    = phys_en_r;
  assign bus.ball_reset = ball_reset_r;
  assign bus.serve_dir  = serve_dir_r;
  assign bus.score      = {opp_score, player_score};
  assign bus.state      = st;
  assign bus.game_over  = game_over_r;
  assign bus.winner     = winner_r;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: reference model compared every cycle plus literal checkpoints.
module tb_pong_match_ctrl;
  localparam int SD  = 3;
  localparam int WIN = 2;

  logic clk;
  logic rst_n;
  pong_match_if #(.SCORE_W(4)) bus ();

  pong_match_ctrl #(.SERVE_DELAY(SD), .WIN_SCORE(WIN), .SCORE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 0;
  logic sb_lvl = 1'b0;
  logic pa_lvl = 1'b0;

  // reference model: match phase, serve countdown, both scores
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_SCORED = 3, M_OVER = 4;
  int   m_mode;
  int   m_left;
  int   m_pl;
  int   m_op;
  logic m_sdir;
  logic m_win;
  logic m_phys;
  logic m_brst;
  logic m_sq;
  logic m_for_player;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode <= M_IDLE; m_left <= 0; m_pl <= 0; m_op <= 0;
      m_sdir <= 1'b1; m_win <= 1'b0; m_phys <= 1'b0; m_brst <= 1'b0;
      m_sq <= 1'b0; m_for_player <= 1'b0;
    end else begin
      m_sq   <= bus.start_btn;
      m_phys <= 1'b0;
      m_brst <= 1'b0;
      if (m_mode == M_IDLE || m_mode == M_OVER) begin
        if (bus.start_btn && !m_sq) begin
          m_mode <= M_SERVE; m_pl <= 0; m_op <= 0; m_sdir <= 1'b1;
          m_win <= 1'b0; m_brst <= 1'b1; m_left <= SD;
        end
      end else if (m_mode == M_SERVE) begin
        if (bus.frame_tick && !bus.pause) begin
          m_left <= m_left - 1;
          if (m_left == 1) m_mode <= M_PLAY;
        end
      end else if (m_mode == M_PLAY) begin
        if (bus.miss_left && bus.miss_right) begin
          m_mode <= M_SERVE; m_brst <= 1'b1; m_left <= SD;
        end else if (bus.miss_left || bus.miss_right) begin
          m_mode <= M_SCORED; m_for_player <= bus.miss_left; m_sdir <= bus.miss_right;
        end else begin
          m_phys <= bus.frame_tick && !bus.pause;
        end
      end else begin
        if (m_for_player) m_pl <= m_pl + 1;
        else              m_op <= m_op + 1;
        if ((m_for_player ? m_pl + 1 : m_op + 1) >= WIN) begin
          m_mode <= M_OVER; m_win <= m_for_player;
        end else begin
          m_mode <= M_SERVE; m_brst <= 1'b1; m_left <= SD;
        end
      end
    end
  end

  // scoreboard: one expected output word per cycle, checked on the falling edge
  logic [15:0] exp_q[$];
  logic [15:0] act_w;
  logic [15:0] exp_w;

  always @(negedge clk) begin
    if (armed) begin
      exp_q.push_back({3'(m_mode), 4'(m_op), 4'(m_pl), m_phys, m_brst, m_sdir,
                       (m_mode == M_OVER), m_win});
      exp_w = exp_q.pop_front();
      act_w = {bus.state, bus.score, bus.phys_en, bus.ball_reset, bus.serve_dir,
               bus.game_over, bus.winner};
      n_vec++;
      if (act_w !== exp_w) begin
        n_err++;
        $display("FAIL cycle_model t=%0t got st=%0d sc=%02h pe=%b br=%b sd=%b go=%b w=%b expected st=%0d sc=%02h pe=%b br=%b sd=%b go=%b w=%b",
                 $time, act_w[15:13], act_w[12:5], act_w[4], act_w[3], act_w[2], act_w[1], act_w[0],
                 exp_w[15:13], exp_w[12:5], exp_w[4], exp_w[3], exp_w[2], exp_w[1], exp_w[0]);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic ft, input logic ml, input logic mr);
    bus.frame_tick = ft;
    bus.start_btn  = sb_lvl;
    bus.pause      = pa_lvl;
    bus.miss_left  = ml;
    bus.miss_right = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic serve_out();
    repeat (SD) begin
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic press_start();
    sb_lvl = 1'b0; drive(1'b0, 1'b0, 1'b0);
    sb_lvl = 1'b1; drive(1'b0, 1'b0, 1'b0);
    sb_lvl = 1'b0;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int pe_cnt;

  initial begin
    rst_n = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    armed = 1;
    chk("rst_state", 16'(bus.state), 16'd0);
    chk("rst_score", 16'(bus.score), 16'h00);
    chk("rst_sdir",  16'(bus.serve_dir), 16'd1);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // first start accepted on a high level
    sb_lvl = 1'b1; drive(1'b0, 1'b0, 1'b0); sb_lvl = 1'b0;
    chk("start_state", 16'(bus.state), 16'd1);
    chk("start_brst",  16'(bus.ball_reset), 16'd1);
    chk("start_score", 16'(bus.score), 16'h00);
    drive(1'b0, 1'b0, 1'b0);
    chk("brst_once",   16'(bus.ball_reset), 16'd0);
    serve_out();
    chk("play_state",  16'(bus.state), 16'd2);
    drive(1'b1, 1'b0, 1'b0);
    chk("phys_lat1",   16'(bus.phys_en), 16'd1);

    // player point
    drive(1'b0, 1'b1, 1'b0);
    chk("scored_state", 16'(bus.state), 16'd3);
    drive(1'b0, 1'b0, 1'b0);
    chk("pt_score",  16'(bus.score), 16'h01);
    chk("pt_sdir",   16'(bus.serve_dir), 16'd0);
    chk("pt_brst",   16'(bus.ball_reset), 16'd1);
    serve_out();

    // double miss re-serves without a point
    drive(1'b0, 1'b1, 1'b1);
    chk("dbl_state", 16'(bus.state), 16'd1);
    chk("dbl_score", 16'(bus.score), 16'h01);
    chk("dbl_sdir",  16'(bus.serve_dir), 16'd0);
    serve_out();

    // opponent point with a coincident tick: no step
    drive(1'b1, 1'b0, 1'b1);
    chk("miss_tick_pe", 16'(bus.phys_en), 16'd0);
    drive(1'b0, 1'b0, 1'b0);
    chk("opp_score", 16'(bus.score), 16'h11);
    chk("opp_sdir",  16'(bus.serve_dir), 16'd1);
    serve_out();

    // start held through the winning point must not restart
    sb_lvl = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    chk("over_state", 16'(bus.state), 16'd4);
    chk("over_score", 16'(bus.score), 16'h21);
    chk("over_go",    16'(bus.game_over), 16'd1);
    chk("over_win",   16'(bus.winner), 16'd0);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    chk("held_start", 16'(bus.state), 16'd4);
    press_start();
    chk("restart_state", 16'(bus.state), 16'd1);
    chk("restart_score", 16'(bus.score), 16'h00);

    // opponent wins 2-0
    drive(1'b0, 1'b0, 1'b0);
    serve_out(); drive(1'b0, 1'b0, 1'b1); drive(1'b0, 1'b0, 1'b0);
    serve_out(); drive(1'b0, 1'b0, 1'b1); drive(1'b0, 1'b0, 1'b0);
    chk("opp_win_score", 16'(bus.score), 16'h20);
    chk("opp_win_state", 16'(bus.state), 16'd4);

    // player wins 2-0
    press_start();
    serve_out(); drive(1'b0, 1'b1, 1'b0); drive(1'b0, 1'b0, 1'b0);
    serve_out(); drive(1'b0, 1'b1, 1'b0); drive(1'b0, 1'b0, 1'b0);
    chk("pl_win_score", 16'(bus.score), 16'h02);
    chk("pl_win_winner", 16'(bus.winner), 16'd1);

    // pause stalls the serve countdown, then suppresses steps in play
    press_start();
    pa_lvl = 1'b1;
    repeat (4) begin drive(1'b1, 1'b0, 1'b0); drive(1'b0, 1'b0, 1'b0); end
    chk("pause_serve", 16'(bus.state), 16'd1);
    pa_lvl = 1'b0;
    serve_out();
    chk("unpause_play", 16'(bus.state), 16'd2);
    pa_lvl = 1'b1;
    pe_cnt = 0;
    repeat (5) begin
      drive(1'b1, 1'b0, 1'b0); pe_cnt += int'(bus.phys_en);
      drive(1'b0, 1'b0, 1'b0); pe_cnt += int'(bus.phys_en);
    end
    chk("pause_no_pe", 16'(pe_cnt), 16'd0);
    drive(1'b1, 1'b1, 1'b0);
    chk("pause_miss", 16'(bus.state), 16'd3);
    drive(1'b0, 1'b0, 1'b0);
    chk("pause_miss_score", 16'(bus.score), 16'h01);
    pa_lvl = 1'b0;
    serve_out();
    drive(1'b1, 1'b0, 1'b0);

    // reset mid-play
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    chk("rst_mid_state", 16'(bus.state), 16'd0);
    chk("rst_mid_score", 16'(bus.score), 16'h00);
    chk("rst_mid_outs", {11'd0, bus.phys_en, bus.ball_reset, bus.serve_dir, bus.game_over, bus.winner},
        16'b00100);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b0);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
